// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if -- request/result bundle for the sequential binary-to-BCD converter.
//
// Signals:
//   start     requester -> converter  one-cycle conversion request
//   bin_in    requester -> converter  binary operand, BIN_W bits
//   busy      converter -> requester  conversion in progress
//   done      converter -> requester  one-cycle pulse, new result available
//   bcd_out   converter -> requester  result, 4*DIGITS bits, units digit in [3:0]
//   overflow  converter -> requester  value did not fit in DIGITS digits
//
// Modports: master = requester side, slave = converter side.
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out,
        input  overflow
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out,
        output overflow
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq -- sequential double-dabble binary-to-BCD converter.
//
// One double-dabble step per clock: BIN_W shift cycles plus one DONE cycle
// per conversion; the result register holds until the next conversion ends.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   bin2bcd_seq_if.slave (start, bin_in, busy, done, bcd_out, overflow)
//
// Parameters: BIN_W (>=4) binary width, DIGITS (>=1) BCD digits.
// Optional macro BIN2BCD_LZ_BLANK_EN: leading zero digits (above digit 0)
// are written as 4'hF in the result for a display decoder.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; result registers hold the last value
// SHIFT | one add-3 + shift step per cycle, counter counts down
// DONE  | publish accumulator/overflow, pulse done, back to IDLE
module bin2bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic          clk,
    input  logic          rst,
    bin2bcd_seq_if.slave  bus
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BIN_W-1:0]   r_sreg;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf_acc;
    logic [ACC_W-1:0]   r_bcd;
    logic               r_ovf;
    logic               r_done;

    logic               w_busy;
    logic [ACC_W-1:0]   w_acc_adj;
    logic [ACC_W-1:0]   w_acc_shift;
    logic [BIN_W-1:0]   w_sreg_shift;
    logic               w_carry;
    logic [ACC_W-1:0]   w_bcd_res;

    // Add-3 correction on every digit >= 5 before the shift.
    always_comb begin
        w_acc_adj = r_acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_acc[4*d +: 4] >= 4'd5) begin
                w_acc_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
            end
        end
    end

    // Bit leaving the top digit is the overflow carry.
    assign w_carry      = w_acc_adj[ACC_W-1];
    assign w_acc_shift  = {w_acc_adj[ACC_W-2:0], r_sreg[BIN_W-1]};
    assign w_sreg_shift = {r_sreg[BIN_W-2:0], 1'b0};

`ifdef BIN2BCD_LZ_BLANK_EN
    // Blank zero digits from the top down until the first non-zero digit;
    // digit 0 always shows.
    always_comb begin : blank_p
        logic v_lead;
        w_bcd_res = r_acc;
        v_lead    = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (v_lead && (r_acc[4*d +: 4] == 4'd0)) begin
                w_bcd_res[4*d +: 4] = 4'hF;
            end else begin
                v_lead = 1'b0;
            end
        end
    end
`else
    assign w_bcd_res = r_acc;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_busy = 1'b1;
                // Counter hits zero on this edge: last shift step.
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sreg    <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf_acc <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sreg    <= bus.bin_in;
                        r_acc     <= '0;
                        r_cnt     <= CNT_W'(BIN_W);
                        r_ovf_acc <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_acc  <= w_acc_shift;
                    r_sreg <= w_sreg_shift;
                    r_cnt  <= r_cnt - CNT_W'(1);
                    if (w_carry) begin
                        r_ovf_acc <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_bcd  <= w_bcd_res;
                    r_ovf  <= r_ovf_acc;
                    r_done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy     = w_busy;
    assign bus.done     = r_done;
    assign bus.bcd_out  = r_bcd;
    assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq -- self-checking bench for bin2bcd_seq.
// Three instances share clk/rst: 8-bit/3 digits, 8-bit/2 digits, 16-bit/5 digits.
// Expected results come from a decimal model (repeated /10 and %10).
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) if0 ();
    bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(2)) if1 ();
    bin2bcd_seq_if #(.BIN_W(16), .DIGITS(5)) if2 ();

    bin2bcd_seq #(.BIN_W(8),  .DIGITS(3)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    bin2bcd_seq #(.BIN_W(8),  .DIGITS(2)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    int n_checks = 0;
    int n_err    = 0;
    int sel      = 0;

    logic        s_busy, s_done, s_ovf;
    logic [19:0] s_bcd;

    always_comb begin
        s_busy = 1'b0;
        s_done = 1'b0;
        s_ovf  = 1'b0;
        s_bcd  = '0;
        case (sel)
            0: begin s_busy = if0.busy; s_done = if0.done; s_ovf = if0.overflow; s_bcd = {8'd0,  if0.bcd_out}; end
            1: begin s_busy = if1.busy; s_done = if1.done; s_ovf = if1.overflow; s_bcd = {12'd0, if1.bcd_out}; end
            default: begin s_busy = if2.busy; s_done = if2.done; s_ovf = if2.overflow; s_bcd = if2.bcd_out; end
        endcase
    end

    function automatic int bw_of(input int which);
        return (which == 2) ? 16 : 8;
    endfunction

    function automatic int nd_of(input int which);
        return (which == 0) ? 3 : (which == 1) ? 2 : 5;
    endfunction

    function automatic longint pow10(input int n);
        longint p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // Decimal digits of v mod 10^nd, units in [3:0]; blank code applied when enabled.
    function automatic logic [19:0] model_bcd(input longint v, input int nd);
        logic [19:0] r = '0;
        longint m = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
`ifdef BIN2BCD_LZ_BLANK_EN
        for (int i = nd - 1; i >= 1; i--) begin
            if (r[4*i +: 4] != 4'd0) break;
            r[4*i +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input logic s, input longint v);
        case (which)
            0: begin if0.start = s; if0.bin_in = 8'(v);  end
            1: begin if1.start = s; if1.bin_in = 8'(v);  end
            default: begin if2.start = s; if2.bin_in = 16'(v); end
        endcase
    endtask

    // One conversion: checks latency, busy length, result, overflow, done width.
    // poke_mid pulses start with a different operand while busy.
    task automatic run_conv(input int which, input longint v, input bit poke_mid);
        int lat, bcnt, bw;
        bw  = bw_of(which);
        sel = which;
        @(negedge clk);
        drive(which, 1'b1, v);
        @(posedge clk); #1;
        drive(which, 1'b0, 0);
        lat  = -1;
        bcnt = 0;
        for (int j = 0; j <= bw + 6 && lat < 0; j++) begin
            if (j > 0) begin @(posedge clk); #1; end
            if (s_busy) bcnt++;
            if (s_done) lat = j;
            if (poke_mid && j == 3) drive(which, 1'b1, v ^ 1);
            if (poke_mid && j == 4) drive(which, 1'b0, 0);
        end
        check($sformatf("latency d%0d v=%0d", which, v), lat, bw + 1);
        check($sformatf("busy_len d%0d v=%0d", which, v), bcnt, bw + 1);
        check($sformatf("bcd d%0d v=%0d", which, v), s_bcd, model_bcd(v, nd_of(which)));
        check($sformatf("ovf d%0d v=%0d", which, v), s_ovf, (v >= pow10(nd_of(which))) ? 1 : 0);
        @(posedge clk); #1;
        check($sformatf("done_width d%0d", which), s_done, 0);
        check($sformatf("bcd_hold d%0d", which), s_bcd, model_bcd(v, nd_of(which)));
    endtask

    initial begin
        int k, dcnt;
        longint v1, v2;
        rst = 1'b1;
        drive(0, 1'b0, 0);
        drive(1, 1'b0, 0);
        drive(2, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        for (int w = 0; w < 3; w++) begin
            sel = w;
            #1;
            check($sformatf("rst_busy d%0d", w), s_busy, 0);
            check($sformatf("rst_done d%0d", w), s_done, 0);
            check($sformatf("rst_bcd d%0d", w), s_bcd, 0);
            check($sformatf("rst_ovf d%0d", w), s_ovf, 0);
        end
        @(negedge clk);
        rst = 1'b0;

        // 8-bit / 3 digits directed values
        run_conv(0, 255, 1'b0);
        run_conv(0, 7, 1'b0);
        run_conv(0, 0, 1'b0);
        run_conv(0, 100, 1'b0);
        // 16-bit / 5 digits
        run_conv(2, 65535, 1'b0);
        run_conv(2, 0, 1'b0);
        run_conv(2, 10000, 1'b0);
        // 8-bit / 2 digits, overflow boundary
        run_conv(1, 100, 1'b0);
        run_conv(1, 99, 1'b0);
        run_conv(1, 255, 1'b0);

        // start while busy is ignored
        run_conv(0, 123, 1'b1);
        run_conv(2, 40961, 1'b1);

        // randomized
        for (int i = 0; i < 8; i++) run_conv(0, $urandom_range(0, 255), 1'b0);
        for (int i = 0; i < 8; i++) run_conv(1, $urandom_range(0, 255), 1'b0);
        for (int i = 0; i < 8; i++) run_conv(2, $urandom_range(0, 65535), 1'b0);

        // back-to-back: start in the done cycle
        sel = 0;
        v1  = 201;
        v2  = 58;
        @(negedge clk);
        drive(0, 1'b1, v1);
        @(posedge clk); #1;
        drive(0, 1'b0, 0);
        k = 0;
        while (!s_done && k < 30) begin @(posedge clk); #1; k++; end
        check("b2b_first_done", s_done, 1);
        check("b2b_first_bcd", s_bcd, model_bcd(v1, 3));
        drive(0, 1'b1, v2);
        @(posedge clk); #1;
        drive(0, 1'b0, 0);
        k = 1;
        while (!s_done && k < 30) begin @(posedge clk); #1; k++; end
        check("b2b_period", k, 10);
        check("b2b_second_bcd", s_bcd, model_bcd(v2, 3));

        // reset mid-conversion (shift cycle 3), with a start in the reset cycle
        sel = 1;
        @(negedge clk);
        drive(1, 1'b1, 57);
        @(posedge clk); #1;
        drive(1, 1'b0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1, 1'b1, 42);
        @(posedge clk); #1;
        check("abort_busy", s_busy, 0);
        check("abort_done", s_done, 0);
        check("abort_bcd", s_bcd, 0);
        check("abort_ovf", s_ovf, 0);
        rst = 1'b0;
        drive(1, 1'b0, 0);
        dcnt = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (s_done || s_busy) dcnt++;
        end
        check("abort_no_done_busy", dcnt, 0);
        run_conv(1, 57, 1'b0);

        // start on the first edge after reset release
        sel = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b1, 96);
        @(posedge clk); #1;
        drive(0, 1'b0, 0);
        check("post_rst_accept", s_busy, 1);
        k = 0;
        while (!s_done && k < 30) begin @(posedge clk); #1; k++; end
        check("post_rst_latency", k, 9);
        check("post_rst_bcd", s_bcd, model_bcd(96, 3));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
